// File: rtl/gamepad_scanner.sv
// gamepad_scanner: drives latch/clk/select of NES/SNES shift-register pads
// and gathers 16-bit active-high button words for N = DATA_WIDTH<<SEL_WIDTH pads.
// Ports: clk, rst (sync, high), ctrl_run; gp_sel/gp_latch/gp_clk to pads;
// gp_data from pads (active low); gp_value flat words; scan_done pulse.
module gamepad_scanner #(
  parameter int DIV        = 150,
  parameter int SEL_WIDTH  = 1,
  parameter int DATA_WIDTH = 2,
  localparam int N  = DATA_WIDTH << SEL_WIDTH,
  localparam int SL = (SEL_WIDTH > 0) ? SEL_WIDTH - 1 : 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_run,
  output logic [SL:0]           gp_sel,
  input  logic [DATA_WIDTH-1:0] gp_data,
  output logic                  gp_latch,
  output logic                  gp_clk,
  output logic [16*N-1:0]       gp_value,
  output logic                  scan_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam int NG = 1 << SEL_WIDTH;
  localparam logic [SL:0] SLAST = (SL+1)'(NG - 1);
  localparam logic [SL:0] SONE = (SL+1)'(1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LATCH, SHIFT_LO, SHIFT_HI
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ph_q, ph_d;
  logic [3:0] b_q, b_d;
  logic [SL:0] s_q, s_d;
  logic [DATA_WIDTH-1:0][15:0] sr_q, sr_d;
  logic [16*N-1:0] val_q, val_d;
  logic latch_q, latch_d;
  logic pclk_q, pclk_d;
  logic done_q, done_d;
  logic tick;

  assign tick = (cnt_q == CMAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    b_d     = b_q;
    s_d     = s_q;
    sr_d    = sr_q;
    val_d   = val_q;
    done_d  = 1'b0;

    if (state_q == IDLE) cnt_d = '0;
    else if (tick) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (ctrl_run) begin
          state_d = SETUP;
          s_d     = '0;
          ph_d    = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          ph_d = ~ph_q;
          if (ph_q) state_d = LATCH;
        end
      end
      LATCH: begin
        if (tick) begin
          ph_d = ~ph_q;
          if (ph_q) begin
            state_d = SHIFT_LO;
            b_d     = '0;
          end
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          // Shift in from the top so bit 0 lands at the LSB after 16 bits.
          for (int d = 0; d < DATA_WIDTH; d++)
            sr_d[d] = {~gp_data[d], sr_q[d][15:1]};
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          if (b_q != 4'd15) begin
            b_d     = b_q + 1'b1;
            state_d = SHIFT_LO;
          end else begin
            for (int d = 0; d < DATA_WIDTH; d++)
              val_d[(int'(s_q)*DATA_WIDTH + d)*16 +: 16] = sr_q[d];
            if (s_q != SLAST) begin
              s_d     = s_q + SONE;
              state_d = SETUP;
            end else begin
              done_d  = 1'b1;
              s_d     = '0;
              state_d = ctrl_run ? SETUP : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == LATCH);
    pclk_d  = (state_d != SHIFT_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      b_q     <= '0;
      s_q     <= '0;
      sr_q    <= '0;
      val_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sr_q    <= sr_d;
      val_q   <= val_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      done_q  <= done_d;
    end
  end

  assign gp_sel    = s_q;
  assign gp_latch  = latch_q;
  assign gp_clk    = pclk_q;
  assign gp_value  = val_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_gamepad_scanner.sv
// tb_gamepad_scanner: directed vectors for a 2x2 pad scanner plus
// a single-pad instance for line timing.
module tb_gamepad_scanner;

  logic clk = 1'b0;
  logic rst, run, run2;

  logic [0:0]  sel;
  logic [1:0]  data;
  logic        latch, gclk, done;
  logic [63:0] val;

  logic [0:0]  sel2;
  logic [0:0]  data2;
  logic        latch2, gclk2, done2;
  logic [15:0] val2;

  always #5 clk = ~clk;

  gamepad_scanner #(.DIV(4), .SEL_WIDTH(1), .DATA_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ctrl_run(run),
    .gp_sel(sel), .gp_data(data), .gp_latch(latch),
    .gp_clk(gclk), .gp_value(val), .scan_done(done)
  );

  gamepad_scanner #(.DIV(4), .SEL_WIDTH(0), .DATA_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .ctrl_run(run2),
    .gp_sel(sel2), .gp_data(data2), .gp_latch(latch2),
    .gp_clk(gclk2), .gp_value(val2), .scan_done(done2)
  );

  // Pad models: latch reloads, each gp_clk rise advances to next bit.
  logic [15:0] pad [0:1][0:1];
  logic [15:0] pw2 = 16'hA5C3;
  logic [4:0]  idx = '0, idx2 = '0;
  logic        pc = 1'b1, pc2 = 1'b1;

  always @(posedge clk) begin
    if (latch) idx <= '0;
    else if (gclk && !pc && idx < 5'd16) idx <= idx + 1'b1;
    pc <= gclk;
    if (latch2) idx2 <= '0;
    else if (gclk2 && !pc2 && idx2 < 5'd16) idx2 <= idx2 + 1'b1;
    pc2 <= gclk2;
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      data[d] = (idx < 5'd16) ? ~pad[sel][d][idx[3:0]] : 1'b1;
    data2[0] = (idx2 < 5'd16) ? ~pw2[idx2[3:0]] : 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] w00, w01, w10, w11;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic set_pads(input logic [15:0] a, b, c, e);
    pad[0][0] = a; pad[0][1] = b; pad[1][0] = c; pad[1][1] = e;
  endtask

  task automatic pulse_run;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Waits for scan_done; counts gp_sel==1 cycles and pre-done changes.
  task automatic wait_done(input logic [63:0] old, output bit ok,
                           output int sel1, output bit early);
    ok = 0; sel1 = 0; early = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1; break; end
      if (sel == 1'b1) sel1++;
      if (val !== old) early = 1;
    end
  endtask

  initial begin
    bit ok, early;
    int sel1, k, falls, lc, lowc, fc, dc, dpos;
    bit bl, bc, bs, bv, bd, p;
    logic [63:0] old;

    vecs[0] = '{16'h0001, 16'h8000, 16'h1234, 16'hFFFF,
                64'hFFFF_1234_8000_0001};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                64'h0000_0000_0000_0000};
    vecs[2] = '{16'hA5C3, 16'h5A3C, 16'h0F0F, 16'hF0F0,
                64'hF0F0_0F0F_5A3C_A5C3};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                64'h0000_FFFF_0000_FFFF};

    rst = 1'b1; run = 1'b0; run2 = 1'b0;
    set_pads(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with ctrl_run low.
    bl = 0; bc = 0; bs = 0; bv = 0; bd = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (latch || latch2) bl = 1;
      if (!gclk || !gclk2) bc = 1;
      if (sel != 1'b0 || sel2 != 1'b0) bs = 1;
      if (val != 64'h0 || val2 != 16'h0) bv = 1;
      if (done || done2) bd = 1;
    end
    chk("idle_latch", bl, 0);
    chk("idle_clk", bc, 0);
    chk("idle_sel", bs, 0);
    chk("idle_value", bv, 0);
    chk("idle_done", bd, 0);

    // One scan per vector; ctrl_run drops during group 0 each time.
    for (int v = 0; v < 4; v++) begin
      set_pads(vecs[v].w00, vecs[v].w01, vecs[v].w10, vecs[v].w11);
      pulse_run();
      wait_done(64'h0, ok, sel1, early);
      chk("scan_timeout", ok, 1);
      chk("scan_value", val, vecs[v].exp);
      if (v == 0) chk("sel1_cycles", sel1, 144);
    end

    // After the last scan the lines go idle and gp_value holds.
    bl = 0; bd = 0; bv = 0; bc = 0; bs = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (latch) bl = 1;
      if (!gclk) bc = 1;
      if (sel != 1'b0) bs = 1;
      if (done) bd = 1;
      if (val !== 64'h0000_FFFF_0000_FFFF) bv = 1;
    end
    chk("stop_latch", bl, 0);
    chk("stop_clk", bc, 0);
    chk("stop_sel", bs, 0);
    chk("stop_done", bd, 0);
    chk("stop_hold", bv, 0);

    // Reset during SHIFT_LO of bit 7.
    set_pads(vecs[2].w00, vecs[2].w01, vecs[2].w10, vecs[2].w11);
    pulse_run();
    falls = 0; p = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (p && !gclk) falls++;
      p = gclk;
      if (falls == 8) break;
    end
    chk("rst_reach_bit7", falls, 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_latch", latch, 0);
    chk("rst_clk", gclk, 1);
    chk("rst_sel", sel, 0);
    chk("rst_value", val, 64'h0);
    chk("rst_done", done, 0);
    repeat (20) @(posedge clk);
    #1 chk("rst_idle_clk", gclk, 1);

    // Fresh scan after reset: SETUP lasts 2 ticks with sel 0.
    set_pads(vecs[0].w00, vecs[0].w01, vecs[0].w10, vecs[0].w11);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    k = 0;
    while (!latch && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("setup_clocks", k, 8);
    chk("setup_sel", sel, 0);
    wait_done(64'h0, ok, sel1, early);
    chk("rescan_timeout", ok, 1);
    chk("rescan_value", val, 64'hFFFF_1234_8000_0001);

    // New data for group 1 only: visible exactly at its commit.
    old = val;
    set_pads(16'h0001, 16'h8000, 16'hBEEF, 16'h0F00);
    pulse_run();
    wait_done(old, ok, sel1, early);
    chk("chg_timeout", ok, 1);
    chk("chg_early", early, 0);
    chk("chg_value", val, 64'h0F00_BEEF_8000_0001);

    // Single-pad instance: value and line timing over one full scan.
    run2 = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done2) begin ok = 1; break; end
    end
    chk("s2_timeout", ok, 1);
    chk("s2_value", val2, 16'hA5C3);
    lc = 0; lowc = 0; fc = 0; dc = 0; dpos = 0; p = 1;
    for (int i = 1; i <= 144; i++) begin
      @(posedge clk); #1;
      if (latch2) lc++;
      if (!gclk2) lowc++;
      if (p && !gclk2) fc++;
      p = gclk2;
      if (done2) begin dc++; dpos = i; end
    end
    chk("s2_latch_clks", lc, 8);
    chk("s2_low_clks", lowc, 64);
    chk("s2_falls", fc, 16);
    chk("s2_done_count", dc, 1);
    chk("s2_done_period", dpos, 144);
    chk("s2_sel", sel2, 0);
    run2 = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done2) begin ok = 1; break; end
    end
    chk("s2_stop_timeout", ok, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("s2_hold", val2, 16'hA5C3);
    chk("s2_idle_clk", gclk2, 1);
    chk("s2_idle_latch", latch2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gamepad_scanner.md
# gamepad_scanner

Serial game-controller scanner that drives the latch/clock/select lines of NES/SNES-style shift-register pads and assembles the 16-bit button words. It sits directly below the gamepad Wishbone CSR block: that block supplies `ctrl_run` and reads the flat `gp_value` vector. The scanner handles all protocol timing, active-low inversion and multiplexing across select lines.

## Interface

- `DIV`, 150: system clocks per protocol tick, ≥ 2.
- `SEL_WIDTH`, 1: width of the select bus; 2^SEL_WIDTH select groups; 0 means a single group with `gp_sel` tied 0.
- `DATA_WIDTH`, 2: number of parallel data lines, one controller per line per select group.
- `N` (derived) = DATA_WIDTH << SEL_WIDTH controllers; SL = max(SEL_WIDTH-1, 0).

Ports:

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `ctrl_run` in 1: enable continuous scanning.
- `gp_sel` out SL+1: current select group.
- `gp_data` in DATA_WIDTH: serial data from pads, active low (0 = pressed).
- `gp_latch` out 1: parallel-load strobe to pads, active high.
- `gp_clk` out 1: shift clock to pads, idle high.
- `gp_value` out 16·N: button words; controller k is at bits [16k+15:16k], with k = s·DATA_WIDTH + d.
- `scan_done` out 1: one-cycle pulse when a full scan of all groups has been committed.

## Operation

- Tick generator: counter 0..DIV-1. It is held at 0 in IDLE. A tick is a cycle in which the counter equals DIV-1. The FSM advances only on ticks.
- FSM states: IDLE, SETUP, LATCH, SHIFT_LO, SHIFT_HI.
  - IDLE: if `ctrl_run`=1, go to SETUP with s=0 (transition on the cycle `ctrl_run` is seen, not on a tick).
  - SETUP, 2 ticks: `gp_sel`=s, `gp_latch`=0, `gp_clk`=1.
  - LATCH, 2 ticks: `gp_latch`=1. Then go to SHIFT_LO with bit index b=0.
  - SHIFT_LO, 1 tick: `gp_clk`=0. On the tick ending this state, sample `~gp_data[d]` into shift register d, bit b.
  - SHIFT_HI, 1 tick: `gp_clk`=1.
    - If b<15: b++ and go to SHIFT_LO.
    - If b=15: commit all DATA_WIDTH shift registers to the group-s slices of `gp_value`.
      - If s < 2^SEL_WIDTH-1: s++ and go to SETUP.
      - Else: pulse `scan_done` and go to SETUP (s=0) if `ctrl_run`=1, otherwise go to IDLE.
- The first bit shifted is bit 0; bit 15 is the last.
- `ctrl_run` is sampled only at the full-scan boundary. Deasserting it mid-scan completes the current full scan.
- `gp_value` is updated one group slice at a time. A slice never shows partial bits. Slices not being committed hold their value.
- With `ctrl_run`=0, `gp_value` retains its last contents indefinitely.

## Timing

- All outputs are registered. Line changes appear on the clk edge following the tick that ends the previous state.
- Per group: 2 + 2 + 32 = 36 ticks. Full scan: 36·2^SEL_WIDTH ticks = 36·DIV·2^SEL_WIDTH clocks, back-to-back while running.
- `gp_clk` low and high phases are each DIV clocks. Latch high is 2·DIV clocks. Select settles 2·DIV clocks before latch.
- The `gp_value` slice updates in the cycle after the final SHIFT_HI tick. `scan_done` is asserted in that same cycle.
- Reset values: `gp_sel`=0, `gp_latch`=0, `gp_clk`=1, `gp_value`=0, `scan_done`=0, FSM=IDLE, tick counter=0.
- Reset mid-scan aborts immediately; outputs take reset values on the next edge. No partial commit is made.
- With SEL_WIDTH=0, `gp_sel` is constant 0 and each scan is a single 36-tick group.

## Test plan

- Reset, `ctrl_run`=0 for 1000 cycles: `gp_latch`=0, `gp_clk`=1, `gp_sel`=0 constant, `gp_value`=0, no `scan_done`.
- DIV=4, SEL_WIDTH=0, DATA_WIDTH=1; pad model returns active-low 0xA5C3, bit 0 first: `gp_value`=0xA5C3. Latch high for exactly 8 clks, 16 low pulses of 4 clks each, `scan_done` once per 144 clks.
- DIV=4, SEL_WIDTH=1, DATA_WIDTH=2; pads (s,d): (0,0)=0x0001, (0,1)=0x8000, (1,0)=0x1234, (1,1)=0xFFFF: `gp_value`=0xFFFF_1234_8000_0001. `gp_sel` is 1 only during the second group.
- Drop `ctrl_run` during group 0 of a scan: group 1 still completes and commits, `scan_done` pulses, then IDLE. `gp_value` is held and the lines return to idle levels.
- Assert `rst` during SHIFT_LO of bit 7: next edge gives all outputs their reset values, including `gp_value`=0, with no partially shifted data visible. Re-enable: a fresh scan starts at SETUP, s=0.
- Change pad data between scans: the old value remains until the affected group's commit cycle, and other groups' slices are unchanged at that cycle.
